// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if: requester, shared-adder and response signals of the adder arbiter.
interface adder_share_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 12,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [2*W-1:0]    add_in;
   logic [W:0]        add_out;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [W:0]        rsp_sum;
   logic              rsp_ready;
   logic              busy;
   modport master (
      output req_valid, req_a, req_b, add_out, rsp_ready,
      input  req_ready, add_in, rsp_valid, rsp_id, rsp_sum, busy
   );
   modport slave (
      input  req_valid, req_a, req_b, add_out, rsp_ready,
      output req_ready, add_in, rsp_valid, rsp_id, rsp_sum, busy
   );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one external combinational adder among NREQ requesters.
module adder_share_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 12,
   parameter int IDW  = 2
) (
   input logic clk,
   input logic rst_n,
   adder_share_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]     state;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] sel_id;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic           rsp_valid;
   logic [IDW-1:0] rsp_id;
   logic [W:0]     rsp_sum;
   logic [IDW-1:0] win;
   logic           found;
   int             j;

   // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
   always_comb begin
      win   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = int'(rr_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (bus.req_valid[j]) begin
            win   = IDW'(j);
            found = 1'b1;
         end
      end
   end

   assign bus.req_ready = (state == IDLE && rst_n && found) ? (NREQ'(1) << win) : '0;
   assign bus.busy      = state != IDLE;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_id    = rsp_id;
   assign bus.rsp_sum   = rsp_sum;

   for (genvar k = 0; k < W; k++) begin : g_ilv
      assign bus.add_in[2*k]   = op_a[k];
      assign bus.add_in[2*k+1] = op_b[k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         sel_id    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
      end else if (state == IDLE) begin
         if (found) begin
            op_a   <= bus.req_a[int'(win)*W +: W];
            op_b   <= bus.req_b[int'(win)*W +: W];
            sel_id <= win;
            state  <= EXEC;
         end
      end else if (state == EXEC) begin
         rsp_sum   <= bus.add_out;
         rsp_id    <= sel_id;
         rsp_valid <= 1'b1;
         state     <= RESP;
      end else if (state == RESP) begin
         if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (sel_id == IDW'(NREQ - 1)) ? '0 : sel_id + 1'b1;
            state     <= IDLE;
         end
      end else begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed and random transactions checked against a round-robin reference model.
module tb_adder_share_arbiter;
   localparam int N   = 4;
   localparam int W   = 12;
   localparam int IDW = 2;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   ptr    = 0;
   logic [W-1:0] ad_a;
   logic [W-1:0] ad_b;

   adder_share_arbiter_if #(.NREQ(N), .W(W), .IDW(IDW)) ifc ();

   adder_share_arbiter #(.NREQ(N), .W(W), .IDW(IDW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External adder: de-interleave the bus and add.
   always_comb begin
      ad_a = '0;
      ad_b = '0;
      for (int k = 0; k < W; k++) begin
         ad_a[k] = ifc.add_in[2*k];
         ad_b[k] = ifc.add_in[2*k+1];
      end
   end
   assign ifc.add_out = {1'b0, ad_a} + {1'b0, ad_b};

   function automatic logic [2*W-1:0] ilv(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] r;
      for (int k = 0; k < W; k++) begin
         r[2*k]   = a[k];
         r[2*k+1] = b[k];
      end
      return r;
   endfunction

   function automatic int pick(input logic [N-1:0] v);
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input logic [N-1:0] v, input logic [N*W-1:0] av, input logic [N*W-1:0] bv,
                      input int d, input bool_rand);
      int w;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   s;
      ifc.req_valid = v;
      ifc.req_a     = av;
      ifc.req_b     = bv;
      ifc.rsp_ready = 1'b0;
      #1;
      w = pick(v);
      if (w < 0) begin
         check("idle_ready", 32'(ifc.req_ready), 0);
         check("idle_busy", 32'(ifc.busy), 0);
         tick();
         check("idle_stay", 32'(ifc.busy), 0);
         return;
      end
      a = av[w*W +: W];
      b = bv[w*W +: W];
      s = {1'b0, a} + {1'b0, b};
      check("grant", 32'(ifc.req_ready), 32'(1) << w);
      check("pre_busy", 32'(ifc.busy), 0);
      tick();
      ifc.req_a     = (N*W)'({$urandom(), $urandom()});
      ifc.req_b     = (N*W)'({$urandom(), $urandom()});
      ifc.req_valid = bool_rand ? N'($urandom()) : v;
      #1;
      check("exec_busy", 32'(ifc.busy), 1);
      check("exec_ready", 32'(ifc.req_ready), 0);
      check("add_in", 32'(ifc.add_in), 32'(ilv(a, b)));
      check("exec_rsp_valid", 32'(ifc.rsp_valid), 0);
      tick();
      check("rsp_valid", 32'(ifc.rsp_valid), 1);
      check("rsp_sum", 32'(ifc.rsp_sum), 32'(s));
      check("rsp_id", 32'(ifc.rsp_id), 32'(w));
      for (int i = 0; i < d; i++) begin
         tick();
         check("hold_valid", 32'(ifc.rsp_valid), 1);
         check("hold_sum", 32'(ifc.rsp_sum), 32'(s));
         check("hold_id", 32'(ifc.rsp_id), 32'(w));
         check("hold_ready", 32'(ifc.req_ready), 0);
      end
      ifc.rsp_ready = 1'b1;
      tick();
      check("done_valid", 32'(ifc.rsp_valid), 0);
      check("done_busy", 32'(ifc.busy), 0);
      ifc.rsp_ready = 1'b0;
      ptr = (w + 1) % N;
   endtask

   initial begin
      rst_n         = 1'b0;
      ifc.req_valid = '1;
      ifc.req_a     = '0;
      ifc.req_b     = '0;
      ifc.rsp_ready = 1'b0;
      #1;
      check("rst_ready", 32'(ifc.req_ready), 0);
      check("rst_valid", 32'(ifc.rsp_valid), 0);
      check("rst_busy", 32'(ifc.busy), 0);
      check("rst_add_in", 32'(ifc.add_in), 0);
      check("rst_sum", 32'(ifc.rsp_sum), 0);
      check("rst_id", 32'(ifc.rsp_id), 0);
      tick();
      tick();
      rst_n = 1'b1;
      // All four requesting: grants go 0,1,2,3,0.
      for (int i = 0; i < 5; i++) begin
         check("rr_order", 32'(pick(4'b1111)), 32'(i % N));
         txn(4'b1111, (N*W)'({$urandom(), $urandom()}), (N*W)'({$urandom(), $urandom()}), 0, 1'b0);
      end
      txn(4'b0001, 48'h000_000_000_FFF, 48'h000_000_000_001, 0, 1'b1);
      txn(4'b0001, 48'h000_000_000_123, 48'h000_000_000_456, 5, 1'b1);
      // Bring ptr to 2, then 1 and 3 compete.
      txn(4'b0010, 48'h000_000_7FF_000, 48'h000_000_801_000, 0, 1'b1);
      check("ptr_two", 32'(ptr), 2);
      txn(4'b1010, 48'hABC_000_111_000, 48'h543_000_222_000, 1, 1'b0);
      txn(4'b1010, 48'hABC_000_111_000, 48'h543_000_222_000, 0, 1'b0);
      check("ptr_end", 32'(ptr), 2);
      txn(4'b1111, 48'h004_003_002_001, 48'h040_030_020_010, 0, 1'b1);
      // Reset asserted while a response is pending.
      ifc.req_valid = 4'b1111;
      ifc.req_a     = 48'h111_111_111_111;
      ifc.req_b     = 48'h222_222_222_222;
      tick();
      tick();
      tick();
      check("pre_rst_valid", 32'(ifc.rsp_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", 32'(ifc.rsp_valid), 0);
      check("async_busy", 32'(ifc.busy), 0);
      check("async_add_in", 32'(ifc.add_in), 0);
      check("async_ready", 32'(ifc.req_ready), 0);
      check("async_sum", 32'(ifc.rsp_sum), 0);
      tick();
      rst_n = 1'b1;
      ptr   = 0;
      txn(4'b1111, 48'h00A_00B_00C_00D, 48'h001_002_003_004, 0, 1'b1);
      for (int i = 0; i < 30; i++)
         txn(N'($urandom()), (N*W)'({$urandom(), $urandom()}), (N*W)'({$urandom(), $urandom()}),
             int'($urandom_range(0, 3)), 1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
